axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Param LINE_BEATS, default 16, number of beats in a cache-line burst.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 X_rd_req  in  1  read request, X in {ic, dc}; ic = icache, dc = dcache.
REQ-005 X_rd_type  in  3  3'b100 = line burst; 3'b000/001/010 = single beat of byte/half/word.
REQ-006 X_rd_addr  in  32  read address; line requests line-aligned.
REQ-007 X_rd_rdy  out  1  request accepted this cycle (pulse).
REQ-008 X_ret_valid  out  1  return beat valid for requester X.
REQ-009 X_ret_last  out  1  final beat of X's transaction.
REQ-010 ret_data  out  32  shared return data; equals rdata.
REQ-011 arid  out  4  0 = icache, 1 = dcache.
REQ-012 araddr/arlen/arsize  out  32/8/3  AR payload.
REQ-013 arvalid, arready  out, in  1 each  AR handshake.
REQ-014 rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel.
REQ-015 rready  out  1  constant 1.
REQ-016 rd_err  out  1  one-cycle pulse: rresp != 0 or rlast/beat-count mismatch.

Function
REQ-017 FSM states IDLE, AR, R; one outstanding transaction at a time.
REQ-018 IDLE: any X_rd_req -> grant, X_rd_rdy pulse same cycle, latch addr/type/id, go to AR next cycle.
REQ-019 Simultaneous requests: dc wins (fixed priority) unless RD_RR_EN is defined.
REQ-020 AR: arvalid=1 with latched payload, stable until arready; arvalid&arready -> R.
REQ-021 arlen = LINE_BEATS-1 and arsize = 3'b010 for line; arlen = 0 and arsize = type[1:0] otherwise.
REQ-022 R: beat counter cleared on entry, +1 per rvalid beat; X_ret_valid = rvalid & (rid == latched id).
REQ-023 X_ret_last = X_ret_valid & rlast; rlast -> IDLE next cycle; new grant earliest the cycle after.
REQ-024 rlast before count == arlen, or count == arlen without rlast -> rd_err pulse; FSM still ends on rlast.
REQ-025 Beats with rid != latched id: ignored, not counted, rd_err pulse.
REQ-026 X_rd_rdy = 0 outside IDLE; requests held by requester until accepted.

Reset
REQ-027 rst: FSM -> IDLE, counter and latches 0; arvalid, X_rd_rdy, X_ret_valid, X_ret_last, rd_err = 0; arid = 0; araddr = 0.
REQ-028 rst mid-burst abandons the transaction; remaining R beats after release are ignored in IDLE.

Configuration
REQ-029 RD_RR_EN defined: round-robin; last-granted id is lowest priority on next conflict, pointer resets to favour dc.
REQ-030 RD_RR_EN undefined: fixed dc-over-ic priority, no pointer register.

Structure
REQ-031 Shared package: FSM state encoding, RD_TYPE_* constants, ARID_IC/ARID_DC, AXI_SIZE_WORD.
REQ-032 One sub-module rd_grant_sel: combinational grant (fixed or round-robin) from two requests plus pointer.

Verification
REQ-033 ic_rd_req alone, line @0x1FC0_0000 -> ic_rd_rdy 1 cycle, arid=0 arlen=15 arsize=2; 16 rvalid beats -> 16 ic_ret_valid, ic_ret_last on beat 16.
REQ-034 ic and dc request same cycle, RD_RR_EN off -> dc granted; ic granted in the IDLE after dc's rlast.
REQ-035 RD_RR_EN on, both requesting continuously -> grants alternate dc, ic, dc, ic.
REQ-036 dc single word @0x8000_0004, arready delayed 3 cycles -> arvalid and payload stable 4 cycles, arlen=0; one beat with rlast -> dc_ret_last.
REQ-037 Line burst with rlast on beat 10 -> rd_err pulse at beat 10, FSM IDLE next cycle.
REQ-038 rst asserted at beat 5 -> all outputs 0 immediately; stray rvalid after release -> no ret_valid, no grant without a request.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the icache/dcache AXI read arbiter: FSM states,
// request type codes, AXI IDs and the beat size used for cache-line bursts.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } rd_state_e;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [3:0] ARID_IC = 4'd0;
    localparam logic [3:0] ARID_DC = 4'd1;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    function automatic logic isLine(input logic [2:0] rdType);
        return rdType == RD_TYPE_LINE;
    endfunction

endpackage

// File: rtl/rd_grant_sel.sv
// Combinational two-way grant: dcache wins a conflict unless the priority
// pointer currently favours the icache.
module rd_grant_sel (
    input  logic icReq_i,
    input  logic dcReq_i,
    input  logic prioIc_i,
    output logic icGnt_o,
    output logic dcGnt_o
);

    assign icGnt_o = icReq_i && (!dcReq_i || prioIc_i);
    assign dcGnt_o = dcReq_i && (!icReq_i || !prioIc_i);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between icache and dcache, one transaction at a time.
// Defining RD_RR_EN replaces fixed dc-over-ic priority with round-robin.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,

    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,

    output logic [31:0] ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    rd_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        prioIc;
    logic        icGnt;
    logic        dcGnt;
    logic        grantTake;
    logic        lenMismatch;

    rd_grant_sel u_grant_sel (
        .icReq_i  (ic_rd_req),
        .dcReq_i  (dc_rd_req),
        .prioIc_i (prioIc),
        .icGnt_o  (icGnt),
        .dcGnt_o  (dcGnt)
    );

    // Requests are never accepted while reset is held, even though the FSM sits in IDLE.
    assign grantTake = (state_q == ST_IDLE) && !rst && (icGnt || dcGnt);

`ifdef RD_RR_EN
    logic prioIc_q, prioIc_d;

    always_comb begin
        prioIc_d = prioIc_q;
        if (grantTake) begin
            prioIc_d = dcGnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prioIc_q <= 1'b0;
        end else begin
            prioIc_q <= prioIc_d;
        end
    end

    assign prioIc = prioIc_q;
`else
    assign prioIc = 1'b0;
`endif

    assign araddr   = addr_q;
    assign arid     = id_q;
    assign arlen    = isLine(type_q) ? 8'(LINE_BEATS - 1) : 8'd0;
    assign arsize   = isLine(type_q) ? AXI_SIZE_WORD : {1'b0, type_q[1:0]};
    assign ret_data = rdata;
    assign rready   = 1'b1;

    // cnt_q holds beats already received, so the final beat arrives with cnt_q == arlen.
    assign lenMismatch = rlast ? (cnt_q != arlen) : (cnt_q >= arlen);

    assign ic_ret_last = ic_ret_valid && rlast;
    assign dc_ret_last = dc_ret_valid && rlast;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        type_d       = type_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        arvalid      = 1'b0;
        ic_ret_valid = 1'b0;
        dc_ret_valid = 1'b0;
        rd_err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grantTake) begin
                    ic_rd_rdy = icGnt;
                    dc_rd_rdy = dcGnt;
                    addr_d    = dcGnt ? dc_rd_addr : ic_rd_addr;
                    type_d    = dcGnt ? dc_rd_type : ic_rd_type;
                    id_d      = dcGnt ? ARID_DC : ARID_IC;
                    state_d   = ST_AR;
                end
            end

            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    cnt_d   = 8'd0;
                    state_d = ST_R;
                end
            end

            ST_R: begin
                if (rvalid) begin
                    if (rid != id_q) begin
                        rd_err = 1'b1;
                    end else begin
                        ic_ret_valid = (id_q == ARID_IC);
                        dc_ret_valid = (id_q == ARID_DC);
                        cnt_d        = cnt_q + 8'd1;
                        rd_err       = (rresp != 2'b00) || lenMismatch;
                        if (rlast) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            type_q  <= 3'd0;
            id_q    <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: transaction-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_axi_rd_arbiter;

    localparam int LINE_BEATS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_rd_req = 1'b0;
    logic [2:0]  ic_rd_type = 3'd0;
    logic [31:0] ic_rd_addr = 32'd0;
    logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic        dc_rd_req = 1'b0;
    logic [2:0]  dc_rd_type = 3'd0;
    logic [31:0] dc_rd_addr = 32'd0;
    logic        dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0] ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready, rd_err;

    axi_rd_arbiter #(.LINE_BEATS(LINE_BEATS)) dut (
        .clk(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMiss = 0;

    // Reference model: which requester owns the port and how far its transaction has got.
    bit          mBusy = 1'b0;
    bit          mAcc = 1'b0;
    logic [3:0]  mId = 4'd0;
    logic [31:0] mAddr = 32'd0;
    logic [2:0]  mType = 3'd0;
    int          mCnt = 0;
    bit          mPrefIc = 1'b0;

    // Observations of the DUT used by the directed literal checks.
    int nIcRdy, nDcRdy, nIcValid, nDcValid, nIcLast, nDcLast, nErr, nArvalid;
    int icLastAt, errAt, payloadChanges;
    int grantLog[$];
    logic [31:0] capAraddr;
    logic [7:0]  capArlen;
    logic [2:0]  capArsize;
    logic [3:0]  capArid;
    bit prevArvalid = 1'b0;
    bit icRdySeen = 1'b0, dcRdySeen = 1'b0;
    bit icCont = 1'b0, dcCont = 1'b0, randMode = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearCounters();
        nIcRdy = 0; nDcRdy = 0; nIcValid = 0; nDcValid = 0; nIcLast = 0; nDcLast = 0;
        nErr = 0; nArvalid = 0; icLastAt = 0; errAt = 0; payloadChanges = 0;
        grantLog.delete();
    endtask

    // 1 = icache wins, 2 = dcache wins, 0 = nobody asking.
    function automatic int pickWinner();
        if (ic_rd_req && dc_rd_req) begin
`ifdef RD_RR_EN
            return mPrefIc ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dc_rd_req) return 2;
        if (ic_rd_req) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy <= 1'b0; mAcc <= 1'b0; mId <= 4'd0; mAddr <= 32'd0;
            mType <= 3'd0; mCnt <= 0; mPrefIc <= 1'b0;
        end else if (!mBusy) begin
            case (pickWinner())
                1: begin
                    mBusy <= 1'b1; mAcc <= 1'b0; mId <= 4'd0;
                    mAddr <= ic_rd_addr; mType <= ic_rd_type; mPrefIc <= 1'b0;
                end
                2: begin
                    mBusy <= 1'b1; mAcc <= 1'b0; mId <= 4'd1;
                    mAddr <= dc_rd_addr; mType <= dc_rd_type; mPrefIc <= 1'b1;
                end
                default: ;
            endcase
        end else if (!mAcc) begin
            if (arready) begin
                mAcc <= 1'b1;
                mCnt <= 0;
            end
        end else if (rvalid && rid == mId) begin
            mCnt <= mCnt + 1;
            if (rlast) begin
                mBusy <= 1'b0;
                mAcc <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w, n, lenExp;
        bit beat, match, expErr;
        logic [2:0] expSize;
        w       = (!mBusy && !rst) ? pickWinner() : 0;
        lenExp  = (mType == 3'b100) ? LINE_BEATS : 1;
        expSize = (mType == 3'b100) ? 3'd2 : {1'b0, mType[1:0]};
        beat    = mBusy && mAcc && rvalid;
        match   = beat && (rid == mId);
        n       = mCnt + 1;
        expErr  = beat && (!match || rresp != 2'd0 || (rlast ? (n != lenExp) : (n >= lenExp)));

        checkOutput("ic_rd_rdy", 32'(ic_rd_rdy), 32'(w == 1));
        checkOutput("dc_rd_rdy", 32'(dc_rd_rdy), 32'(w == 2));
        checkOutput("arvalid", 32'(arvalid), 32'(mBusy && !mAcc));
        checkOutput("araddr", araddr, mAddr);
        checkOutput("arid", 32'(arid), 32'(mId));
        checkOutput("arlen", 32'(arlen), 32'(lenExp - 1));
        checkOutput("arsize", 32'(arsize), 32'(expSize));
        checkOutput("ic_ret_valid", 32'(ic_ret_valid), 32'(match && mId == 4'd0));
        checkOutput("dc_ret_valid", 32'(dc_ret_valid), 32'(match && mId == 4'd1));
        checkOutput("ic_ret_last", 32'(ic_ret_last), 32'(match && mId == 4'd0 && rlast));
        checkOutput("dc_ret_last", 32'(dc_ret_last), 32'(match && mId == 4'd1 && rlast));
        checkOutput("ret_data", ret_data, rdata);
        checkOutput("rready", 32'(rready), 32'd1);
        checkOutput("rd_err", 32'(rd_err), 32'(expErr));

        icRdySeen = ic_rd_rdy;
        dcRdySeen = dc_rd_rdy;
        if (ic_rd_rdy) begin nIcRdy++; grantLog.push_back(0); end
        if (dc_rd_rdy) begin nDcRdy++; grantLog.push_back(1); end
        if (ic_ret_valid) nIcValid++;
        if (dc_ret_valid) nDcValid++;
        if (ic_ret_last) begin nIcLast++; icLastAt = nIcValid; end
        if (dc_ret_last) nDcLast++;
        if (rd_err) begin nErr++; errAt = nIcValid + nDcValid; end
        if (arvalid) begin
            nArvalid++;
            if (!prevArvalid) begin
                capAraddr = araddr; capArlen = arlen; capArsize = arsize; capArid = arid;
            end else if (araddr != capAraddr || arlen != capArlen || arsize != capArsize || arid != capArid) begin
                payloadChanges++;
            end
        end
        prevArvalid = arvalid;
    end

    task automatic randPayload(output logic [2:0] t, output logic [31:0] a);
        int k;
        k = int'($urandom_range(0, 3));
        t = (k == 3) ? 3'b100 : 3'(k);
        a = $urandom;
        if (k == 3) a[5:0] = 6'd0;
    endtask

    // Requesters hold a request until it is accepted, then drop or renew it.
    always begin
        @(posedge clk);
        #1;
        if (icRdySeen) begin
            ic_rd_req = icCont;
            if (icCont) randPayload(ic_rd_type, ic_rd_addr);
        end else if (randMode && !ic_rd_req && $urandom_range(0, 3) == 0) begin
            ic_rd_req = 1'b1;
            randPayload(ic_rd_type, ic_rd_addr);
        end
        if (dcRdySeen) begin
            dc_rd_req = dcCont;
            if (dcCont) randPayload(dc_rd_type, dc_rd_addr);
        end else if (randMode && !dc_rd_req && $urandom_range(0, 3) == 0) begin
            dc_rd_req = 1'b1;
            randPayload(dc_rd_type, dc_rd_addr);
        end
    end

    task automatic applyStimulus(input int who, input logic [2:0] t, input logic [31:0] a);
        if (who == 0) begin
            ic_rd_req = 1'b1; ic_rd_type = t; ic_rd_addr = a;
        end else begin
            dc_rd_req = 1'b1; dc_rd_type = t; dc_rd_addr = a;
        end
    endtask

    // Acts as the AXI slave for one transaction; abortAt > 0 raises reset on that beat.
    task automatic serveRead(input int arDelay, input int lastAt, input bit rnd, input int abortAt);
        int cyc, nBeats, lastBeat;
        logic [3:0] id;
        cyc = 0;
        while (!arvalid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!arvalid) begin
            checkOutput("arvalid_timeout", 32'(arvalid), 32'd1);
            return;
        end
        id = arid;
        nBeats = int'(arlen) + 1;
        repeat (arDelay) begin @(posedge clk); #1; end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        lastBeat = (lastAt > 0) ? lastAt : nBeats;
        if (rnd && $urandom_range(0, 7) == 0) lastBeat = int'($urandom_range(1, nBeats + 1));
        for (int b = 1; b <= lastBeat; b++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 9) == 0) begin
                    rvalid = 1'b1; rid = id ^ 4'($urandom_range(1, 15));
                    rdata = $urandom; rresp = 2'd0; rlast = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    rvalid = 1'b0; rlast = 1'b0;
                end
            end
            rvalid = 1'b1;
            rid    = id;
            rdata  = $urandom;
            rresp  = (rnd && $urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rlast  = (b == lastBeat);
            if (b == abortAt) begin
                #2 rst = 1'b1;
                @(negedge clk);
                return;
            end
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'd0;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expSeq[6];
        clearCounters();
        @(negedge clk);
        checkOutput("reset_arvalid", 32'(arvalid), 32'd0);
        checkOutput("reset_araddr", araddr, 32'd0);
        checkOutput("reset_arid", 32'(arid), 32'd0);
        checkOutput("reset_rd_err", 32'(rd_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] icache line burst");
        clearCounters();
        applyStimulus(0, 3'b100, 32'h1FC0_0000);
        serveRead(0, 0, 1'b0, 0);
        checkOutput("t1_rdy_cycles", 32'(nIcRdy), 32'd1);
        checkOutput("t1_arid", 32'(capArid), 32'd0);
        checkOutput("t1_arlen", 32'(capArlen), 32'd15);
        checkOutput("t1_arsize", 32'(capArsize), 32'd2);
        checkOutput("t1_araddr", capAraddr, 32'h1FC0_0000);
        checkOutput("t1_ret_valid_count", 32'(nIcValid), 32'd16);
        checkOutput("t1_ret_last_count", 32'(nIcLast), 32'd1);
        checkOutput("t1_ret_last_beat", 32'(icLastAt), 32'd16);
        checkOutput("t1_no_err", 32'(nErr), 32'd0);

        $display("[TB] simultaneous requests");
        clearCounters();
        applyStimulus(0, 3'b010, 32'h0000_1000);
        applyStimulus(1, 3'b000, 32'h0000_2003);
        serveRead(0, 0, 1'b0, 0);
        serveRead(0, 0, 1'b0, 0);
        checkOutput("t2_grants", 32'(grantLog.size()), 32'd2);
        checkOutput("t2_first_dc", 32'(grantLog[0]), 32'd1);
        checkOutput("t2_second_ic", 32'(grantLog[1]), 32'd0);
        checkOutput("t2_dc_last", 32'(nDcLast), 32'd1);
        checkOutput("t2_ic_last", 32'(nIcLast), 32'd1);

        $display("[TB] continuous requests from both");
        clearCounters();
        icCont = 1'b1; dcCont = 1'b1;
        applyStimulus(0, 3'b010, 32'h0000_3000);
        applyStimulus(1, 3'b010, 32'h0000_4000);
        repeat (4) serveRead(0, 0, 1'b0, 0);
        icCont = 1'b0; dcCont = 1'b0;
        for (int k = 0; k < 4 && (ic_rd_req || dc_rd_req || arvalid); k++) serveRead(0, 0, 1'b0, 0);
`ifdef RD_RR_EN
        expSeq = '{1, 0, 1, 0, 1, 0};
`else
        expSeq = '{1, 1, 1, 1, 1, 0};
`endif
        checkOutput("t3_grants", 32'(grantLog.size()), 32'd6);
        for (int k = 0; k < 6; k++) checkOutput("t3_grant_order", 32'(grantLog[k]), 32'(expSeq[k]));

        $display("[TB] dcache word with slow arready");
        clearCounters();
        applyStimulus(1, 3'b010, 32'h8000_0004);
        serveRead(3, 0, 1'b0, 0);
        checkOutput("t4_arvalid_cycles", 32'(nArvalid), 32'd4);
        checkOutput("t4_payload_stable", 32'(payloadChanges), 32'd0);
        checkOutput("t4_araddr", capAraddr, 32'h8000_0004);
        checkOutput("t4_arlen", 32'(capArlen), 32'd0);
        checkOutput("t4_arsize", 32'(capArsize), 32'd2);
        checkOutput("t4_arid", 32'(capArid), 32'd1);
        checkOutput("t4_dc_last", 32'(nDcLast), 32'd1);

        $display("[TB] early rlast");
        clearCounters();
        applyStimulus(0, 3'b100, 32'h0000_0400);
        serveRead(0, 10, 1'b0, 0);
        checkOutput("t5_err_count", 32'(nErr), 32'd1);
        checkOutput("t5_err_beat", 32'(errAt), 32'd10);
        checkOutput("t5_beats", 32'(nIcValid), 32'd10);
        applyStimulus(1, 3'b010, 32'h0000_0040);
        @(negedge clk);
        checkOutput("t5_idle_after_last", 32'(dc_rd_rdy), 32'd1);
        @(posedge clk); #1;
        serveRead(0, 0, 1'b0, 0);

        $display("[TB] reset mid-burst");
        clearCounters();
        applyStimulus(0, 3'b100, 32'h0000_0800);
        serveRead(0, 0, 1'b0, 5);
        checkOutput("t6_ret_valid", 32'(ic_ret_valid), 32'd0);
        checkOutput("t6_arvalid", 32'(arvalid), 32'd0);
        checkOutput("t6_rd_err", 32'(rd_err), 32'd0);
        checkOutput("t6_araddr", araddr, 32'd0);
        checkOutput("t6_arid", 32'(arid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = $urandom; rlast = k[0];
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0;
        checkOutput("t6_beats_before_reset", 32'(nIcValid), 32'd4);
        checkOutput("t6_no_new_grant", 32'(grantLog.size()), 32'd1);
        checkOutput("t6_no_err", 32'(nErr), 32'd0);

        $display("[TB] randomized traffic");
        randMode = 1'b1;
        for (int k = 0; k < 60; k++) serveRead(int'($urandom_range(0, 3)), 0, 1'b1, 0);
        randMode = 1'b0;
        for (int k = 0; k < 4 && (ic_rd_req || dc_rd_req || arvalid); k++) serveRead(0, 0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
